// File: rtl/set_mode_ctrl.sv
// Set-mode controller for the clock/calendar: cycles through the field-select states on mode presses,
// turns up/down presses into inc/dec pulses with auto-repeat, and abandons set mode after idle seconds.
module set_mode_ctrl #(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick_1hz,
  output logic [5:0] set_sel,
  output logic       inc,
  output logic       dec,
  output logic       set_active,
  output logic       blink
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_S + 1);
  localparam logic [REP_W-1:0]  DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_S - 1);

  typedef enum logic [2:0] {
    RUN, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR, SET_MIN, SET_SEC
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic               mode_prev_q, mode_prev_d;
  logic               up_prev_q, up_prev_d;
  logic               down_prev_q, down_prev_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               rep_first_q, rep_first_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [5:0]         set_sel_q, set_sel_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               set_active_q, set_active_d;
  logic               blink_q, blink_d;

  logic in_set, mode_edge, up_edge, down_edge, released, single;
  logic rep_clear, rep_hit, pulse_ok, activity, timeout;

  always_comb begin
    in_set    = (state_q != RUN);
    // armed_q stays low for the first cycle after reset so a held button only loads history
    mode_edge = armed_q & btn_mode & ~mode_prev_q;
    up_edge   = armed_q & btn_up & ~up_prev_q;
    down_edge = armed_q & btn_down & ~down_prev_q;
    released  = (up_prev_q & ~btn_up) | (down_prev_q & ~btn_down);
    single    = btn_up ^ btn_down;

    rep_clear = ~in_set | ~armed_q | mode_edge | ~single | up_edge | down_edge | released;
    rep_hit   = ~rep_clear & (rep_cnt_q == (rep_first_q ? DELAY_LAST : RATE_LAST));
    pulse_ok  = in_set & ~mode_edge;
    inc_d     = pulse_ok & btn_up & ~btn_down & (up_edge | rep_hit);
    dec_d     = pulse_ok & btn_down & ~btn_up & (down_edge | rep_hit);
    activity  = mode_edge | up_edge | down_edge | rep_hit;
    timeout   = in_set & tick_1hz & ~activity & (idle_q == IDLE_LAST);

    armed_d     = 1'b1;
    mode_prev_d = btn_mode;
    up_prev_d   = btn_up;
    down_prev_d = btn_down;

    if (rep_clear | timeout) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_hit) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d   = rep_cnt_q + REP_W'(1);
      rep_first_d = rep_first_q;
    end

    if (~in_set | activity | timeout) begin
      idle_d = '0;
    end else if (tick_1hz) begin
      idle_d = idle_q + IDLE_W'(1);
    end else begin
      idle_d = idle_q;
    end

    // a mode press takes priority over a coincident timeout
    state_d = state_q;
    if (mode_edge) begin
      case (state_q)
        RUN:       state_d = SET_YEAR;
        SET_YEAR:  state_d = SET_MONTH;
        SET_MONTH: state_d = SET_DAY;
        SET_DAY:   state_d = SET_HOUR;
        SET_HOUR:  state_d = SET_MIN;
        SET_MIN:   state_d = SET_SEC;
        default:   state_d = RUN;
      endcase
    end else if (timeout) begin
      state_d = RUN;
    end

    case (state_d)
      SET_YEAR:  set_sel_d = 6'b100000;
      SET_MONTH: set_sel_d = 6'b010000;
      SET_DAY:   set_sel_d = 6'b001000;
      SET_HOUR:  set_sel_d = 6'b000100;
      SET_MIN:   set_sel_d = 6'b000010;
      SET_SEC:   set_sel_d = 6'b000001;
      default:   set_sel_d = 6'b000000;
    endcase
    set_active_d = |set_sel_d;

    if ((state_d == RUN) || (state_d != state_q) || inc_d || dec_d) begin
      blink_d = 1'b1;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      armed_q      <= 1'b0;
      mode_prev_q  <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
      rep_cnt_q    <= '0;
      rep_first_q  <= 1'b1;
      idle_q       <= '0;
      set_sel_q    <= 6'b000000;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      set_active_q <= 1'b0;
      blink_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      mode_prev_q  <= mode_prev_d;
      up_prev_q    <= up_prev_d;
      down_prev_q  <= down_prev_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_first_q  <= rep_first_d;
      idle_q       <= idle_d;
      set_sel_q    <= set_sel_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      set_active_q <= set_active_d;
      blink_q      <= blink_d;
    end
  end

  assign set_sel    = set_sel_q;
  assign inc        = inc_q;
  assign dec        = dec_q;
  assign set_active = set_active_q;
  assign blink      = blink_q;

endmodule

// File: doc/set_mode_ctrl.md
SET_MODE_CTRL -- requirements
Module: set_mode_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 25000000: clock cycles a held up/down button waits before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_RATE, default 5000000: clock cycles between auto-repeat pulses.
REQ-003 SHALL have parameter TIMEOUT_S, default 30: tick_1hz pulses with no button activity before set mode is abandoned.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports below list clock and reset first.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn_mode  input  1  debounced, synchronized mode button level; high means pressed.
REQ-008 btn_up  input  1  debounced, synchronized increment button level.
REQ-009 btn_down  input  1  debounced, synchronized decrement button level.
REQ-010 tick_1hz  input  1  single-cycle 1 Hz strobe from the seconds prescaler.
REQ-011 set_sel  output  6  one-hot field select, used as the per-counter ctrl_set: bit5 year, bit4 month, bit3 day, bit2 hour, bit1 minute, bit0 second.
REQ-012 inc  output  1  single-cycle increment pulse, shared by all counters.
REQ-013 dec  output  1  single-cycle decrement pulse, shared by all counters.
REQ-014 set_active  output  1  high in any SET state.
REQ-015 blink  output  1  display blink phase for the selected field.

Function
REQ-016 States: RUN, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR, SET_MIN, SET_SEC.
REQ-017 Each state is entered and left only on the transitions defined below.
REQ-018 A mode press is a rising edge of btn_mode (sampled high, previous sample low).
REQ-019 Mode presses advance the state cyclically: RUN->SET_YEAR->SET_MONTH->SET_DAY->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-020 set_sel is registered: exactly one bit is high in a SET state, all bits are low in RUN, and it changes in the cycle after the transition edge.
REQ-021 In SET states, a rising edge of btn_up produces inc high for exactly one cycle, asserted in the clock cycle after the edge is sampled.
REQ-022 In SET states, a rising edge of btn_down produces dec in the same way.
REQ-023 Auto-repeat: while a single button stays held, a second pulse occurs REPEAT_DELAY cycles after the first, then one pulse every REPEAT_RATE cycles.
REQ-024 Auto-repeat runs from one shared counter of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
REQ-025 The repeat counter clears on any button release, any new button edge, and any state change.
REQ-026 btn_up and btn_down held together: no inc or dec, repeat counter held at zero; releasing one button does not create a new edge for the other.
REQ-027 inc and dec are never high in the same cycle, never high in RUN, and never high in the cycle a mode press is processed.
REQ-028 A mode press in the same cycle as an up/down edge: the mode press wins and the up/down edge is discarded.
REQ-029 Timeout: an idle counter counts tick_1hz pulses in SET states.
REQ-030 The idle counter clears on any up/down/mode edge and on every auto-repeat pulse.
REQ-031 When the idle count reaches TIMEOUT_S, the state returns to RUN.
REQ-032 A mode press coincident with the timeout wins over the timeout.
REQ-033 blink toggles on each tick_1hz while in a SET state.
REQ-034 blink is forced high on any inc/dec pulse or state change, and is high in RUN.
REQ-035 set_active equals OR of set_sel.

Reset
REQ-036 rst_n low asynchronously forces state RUN, set_sel=0, inc=0, dec=0, set_active=0, blink=1.
REQ-037 rst_n low asynchronously clears the repeat counter, the idle counter and the button history registers.
REQ-038 A button held through reset release SHALL NOT generate an edge; history resets to the pressed-equivalent of the sampled level in the first cycle after release.

Verification
REQ-039 From reset, 7 mode presses -> set_sel sequence 100000, 010000, 001000, 000100, 000010, 000001, 000000; set_active low at the end.
REQ-040 SET_YEAR, REPEAT_DELAY=10, REPEAT_RATE=4, btn_up held 30 cycles -> inc pulses at cycles 1, 11, 15, 19, 23, 27 after the edge; dec stays 0.
REQ-041 In RUN, toggling btn_up/btn_down -> inc=dec=0; in SET_DAY with both buttons held 50 cycles -> no pulses.
REQ-042 SET_MIN, TIMEOUT_S=3, no buttons, 3 tick_1hz -> RUN after the third tick; a btn_down edge after 2 ticks restarts the count, giving dec=1 once.
REQ-043 Mode edge and btn_up edge in the same cycle in SET_HOUR -> state SET_MIN, no inc.
REQ-044 rst_n asserted mid-repeat in SET_SEC -> all outputs at reset values immediately, before the next clk edge.
